vending_machine_gen: RTL and testbench

VENDING_MACHINE_GEN -- requirements
Module: vending_machine_gen

---
 rtl/vending_machine_gen.sv | 216 +++++++++++++++++++++
 tb/tb_vending_machine_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_gen.sv
// Parameterised vending machine: coin intake with overflow rejection, product
// purchase with stock tracking, and greedy change return from a finite coin
// inventory. All outputs come straight from registers.
module vending_machine_gen #(
    parameter int N_PROD = 8,
    parameter int N_DENOM = 15,
    parameter int CREDIT_W = 20,
    parameter int CNT_W = 8,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {N_PROD{CREDIT_W'(150)}},
    parameter logic [N_DENOM*CREDIT_W-1:0] DENOM_VALUES = {
        CREDIT_W'(1),    CREDIT_W'(2),    CREDIT_W'(5),     CREDIT_W'(10),
        CREDIT_W'(25),   CREDIT_W'(50),   CREDIT_W'(100),   CREDIT_W'(200),
        CREDIT_W'(500),  CREDIT_W'(1000), CREDIT_W'(2000),  CREDIT_W'(5000),
        CREDIT_W'(10000), CREDIT_W'(20000), CREDIT_W'(50000)},
    parameter int DENOM_INIT_CNT = 10,
    parameter int STOCK_INIT = 10,
    localparam int MONEY_W = (N_DENOM > 1) ? $clog2(N_DENOM) : 1,
    localparam int PROD_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [MONEY_W-1:0]  i_money,
    input  logic                i_money_valid,
    input  logic [PROD_W-1:0]   i_product_code,
    input  logic                i_buy,
    input  logic                i_cancel,
    input  logic                i_product_ready,
    output logic [PROD_W-1:0]   o_product_code,
    output logic                o_product_valid,
    output logic                o_busy,
    output logic [MONEY_W-1:0]  o_change_denomination_code,
    output logic                o_change_valid,
    output logic                o_no_change,
    output logic                o_sold_out,
    output logic [CREDIT_W-1:0] o_credit
);

    typedef enum logic [1:0] {IDLE, CHECK, VEND, CHANGE} state_t;

    state_t              state_q, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic [MONEY_W-1:0]  idx_q, idx_n;
    logic [PROD_W-1:0]   prod_q, prod_n;
    logic                busy_q;
    logic                product_valid_q, product_valid_n;
    logic [PROD_W-1:0]   product_code_q, product_code_n;
    logic                change_valid_q, change_valid_n;
    logic [MONEY_W-1:0]  change_code_q, change_code_n;
    logic                no_change_q, no_change_n;
    logic                sold_out_q, sold_out_n;

    logic [CNT_W-1:0]    coin_cnt [N_DENOM];
    logic [CNT_W-1:0]    stock [N_PROD];
    logic [CREDIT_W-1:0] denom_val [N_DENOM];
    logic [CREDIT_W-1:0] price [N_PROD];

    logic                coin_inc, coin_dec, stock_dec;
    logic [MONEY_W-1:0]  coin_sel;
    logic                money_ok, prod_ok;
    logic [MONEY_W-1:0]  money_idx;
    logic [CREDIT_W:0]   credit_sum;

    for (genvar g = 0; g < N_DENOM; g++) begin : g_denom
        assign denom_val[g] = DENOM_VALUES[g*CREDIT_W +: CREDIT_W];
    end

    for (genvar g = 0; g < N_PROD; g++) begin : g_price
        assign price[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    end

    // Out-of-range codes are clamped to index 0 so table lookups stay legal;
    // the ok flags keep such codes from having any effect.
    assign money_ok   = (32'(i_money) < N_DENOM);
    assign prod_ok    = (32'(i_product_code) < N_PROD);
    assign money_idx  = money_ok ? i_money : '0;
    assign credit_sum = {1'b0, credit_q} + {1'b0, denom_val[money_idx]};

    // Next-state, credit and output decisions for every FSM state.
    always_comb begin
        state_n         = state_q;
        credit_n        = credit_q;
        idx_n           = idx_q;
        prod_n          = prod_q;
        product_valid_n = product_valid_q;
        product_code_n  = product_code_q;
        change_valid_n  = 1'b0;
        change_code_n   = change_code_q;
        no_change_n     = 1'b0;
        sold_out_n      = 1'b0;
        coin_inc        = 1'b0;
        coin_dec        = 1'b0;
        coin_sel        = money_idx;
        stock_dec       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_cancel) begin
                    if (credit_q != '0) begin
                        state_n = CHANGE;
                        idx_n   = '0;
                    end
                end else if (i_money_valid) begin
                    if (money_ok) begin
                        if (credit_sum[CREDIT_W]) begin
                            change_valid_n = 1'b1;
                            change_code_n  = i_money;
                        end else begin
                            credit_n = credit_sum[CREDIT_W-1:0];
                            coin_inc = 1'b1;
                        end
                    end
                end else if (i_buy) begin
                    if (prod_ok) begin
                        prod_n  = i_product_code;
                        state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                if (stock[prod_q] == '0) begin
                    sold_out_n = 1'b1;
                    state_n    = IDLE;
                end else if (credit_q < price[prod_q]) begin
                    state_n = IDLE;
                end else begin
                    credit_n        = credit_q - price[prod_q];
                    stock_dec       = 1'b1;
                    product_valid_n = 1'b1;
                    product_code_n  = prod_q;
                    state_n         = VEND;
                end
            end
            VEND: begin
                if (i_product_ready) begin
                    product_valid_n = 1'b0;
                    idx_n           = '0;
                    state_n         = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                coin_sel = idx_q;
                if ((denom_val[idx_q] <= credit_q) && (coin_cnt[idx_q] != '0)) begin
                    change_valid_n = 1'b1;
                    change_code_n  = idx_q;
                    credit_n       = credit_q - denom_val[idx_q];
                    coin_dec       = 1'b1;
                    if (credit_n == '0) begin
                        state_n = IDLE;
                    end
                end else if (32'(idx_q) == N_DENOM - 1) begin
                    no_change_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    idx_n = idx_q + MONEY_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, credit and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            idx_q           <= '0;
            prod_q          <= '0;
            busy_q          <= 1'b0;
            product_valid_q <= 1'b0;
            product_code_q  <= '0;
            change_valid_q  <= 1'b0;
            change_code_q   <= '0;
            no_change_q     <= 1'b0;
            sold_out_q      <= 1'b0;
        end else begin
            state_q         <= state_n;
            credit_q        <= credit_n;
            idx_q           <= idx_n;
            prod_q          <= prod_n;
            busy_q          <= (state_n != IDLE);
            product_valid_q <= product_valid_n;
            product_code_q  <= product_code_n;
            change_valid_q  <= change_valid_n;
            change_code_q   <= change_code_n;
            no_change_q     <= no_change_n;
            sold_out_q      <= sold_out_n;
        end
    end

    // Coin and stock inventory; inserted coins saturate instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_DENOM; i++) coin_cnt[i] <= CNT_W'(DENOM_INIT_CNT);
            for (int i = 0; i < N_PROD; i++) stock[i] <= CNT_W'(STOCK_INIT);
        end else begin
            if (coin_inc && (coin_cnt[coin_sel] != '1)) begin
                coin_cnt[coin_sel] <= coin_cnt[coin_sel] + CNT_W'(1);
            end
            if (coin_dec) begin
                coin_cnt[coin_sel] <= coin_cnt[coin_sel] - CNT_W'(1);
            end
            if (stock_dec) begin
                stock[prod_q] <= stock[prod_q] - CNT_W'(1);
            end
        end
    end

    assign o_product_code             = product_code_q;
    assign o_product_valid            = product_valid_q;
    assign o_busy                     = busy_q;
    assign o_change_denomination_code = change_code_q;
    assign o_change_valid             = change_valid_q;
    assign o_no_change                = no_change_q;
    assign o_sold_out                 = sold_out_q;
    assign o_credit                   = credit_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Scoreboard bench for vending_machine_gen: stimulus pushes the expected
// vend / coin / no-change / sold-out events, a monitor pops and compares them.
module tb_vending_machine_gen;

    localparam int K_COIN  = 0;
    localparam int K_NOCHG = 1;
    localparam int K_SOLD  = 2;
    localparam int K_VEND  = 3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] code;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [3:0]  i_money = '0;
    logic        i_money_valid = 1'b0;
    logic [2:0]  i_product_code = '0;
    logic        i_buy = 1'b0;
    logic        i_cancel = 1'b0;
    logic        i_product_ready = 1'b1;
    logic [2:0]  o_product_code;
    logic        o_product_valid;
    logic        o_busy;
    logic [3:0]  o_change_denomination_code;
    logic        o_change_valid;
    logic        o_no_change;
    logic        o_sold_out;
    logic [19:0] o_credit;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Product 7 costs 170 so a 200 insert returns exactly 30 in change.
    vending_machine_gen #(
        .PRICES({20'd170, {7{20'd150}}})
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_money(i_money),
        .i_money_valid(i_money_valid),
        .i_product_code(i_product_code),
        .i_buy(i_buy),
        .i_cancel(i_cancel),
        .i_product_ready(i_product_ready),
        .o_product_code(o_product_code),
        .o_product_valid(o_product_valid),
        .o_busy(o_busy),
        .o_change_denomination_code(o_change_denomination_code),
        .o_change_valid(o_change_valid),
        .o_no_change(o_no_change),
        .o_sold_out(o_sold_out),
        .o_credit(o_credit)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(int kind, int code, int times);
        exp_t e;
        e.kind = kind[1:0];
        e.code = code[3:0];
        for (int i = 0; i < times; i++) exp_q.push_back(e);
    endtask

    task automatic observe(int kind, int code);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d code %0d, expected no event", kind, code);
        end else begin
            e = exp_q.pop_front();
            if ((32'(e.kind) != kind) || (32'(e.code) != code)) begin
                n_errors++;
                $display("[TB] FAIL event: got kind %0d code %0d, expected kind %0d code %0d",
                         kind, code, e.kind, e.code);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard queue.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_change_valid) observe(K_COIN, int'(o_change_denomination_code));
            if (o_no_change) observe(K_NOCHG, 0);
            if (o_sold_out) observe(K_SOLD, 0);
            if (o_product_valid && i_product_ready) observe(K_VEND, int'(o_product_code));
        end
    end

    task automatic insert(int code);
        i_money = code[3:0];
        i_money_valid = 1'b1;
        tick();
        i_money_valid = 1'b0;
    endtask

    task automatic buy(int prod);
        i_product_code = prod[2:0];
        i_buy = 1'b1;
        tick();
        i_buy = 1'b0;
    endtask

    task automatic cancel();
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (o_busy && n < 300) begin
            tick();
            n++;
        end
        check_output({name, "_idle_timeout"}, 32'(o_busy), 0);
        tick();
    endtask

    task automatic check_zero(string name);
        check_output({name, "_credit"}, 32'(o_credit), 0);
        check_output({name, "_busy"}, 32'(o_busy), 0);
        check_output({name, "_pvalid"}, 32'(o_product_valid), 0);
        check_output({name, "_cvalid"}, 32'(o_change_valid), 0);
        check_output({name, "_nochg"}, 32'(o_no_change), 0);
        check_output({name, "_sold"}, 32'(o_sold_out), 0);
        check_output({name, "_pcode"}, 32'(o_product_code), 0);
        check_output({name, "_ccode"}, 32'(o_change_denomination_code), 0);
    endtask

    task automatic do_reset(string name);
        i_rst_n = 1'b0;
        #1;
        check_zero(name);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick();
    endtask

    // Directed scenarios.
    initial begin
        #3;
        do_reset("rst0");

        // 100 + 50, buy product 0: exact payment, no change
        insert(8);
        insert(9);
        check_output("credit_150", 32'(o_credit), 150);
        push_exp(K_VEND, 0, 1);
        buy(0);
        wait_idle("exact");
        check_output("exact_credit", 32'(o_credit), 0);

        // 200, buy product 0: one 50 back
        insert(7);
        push_exp(K_VEND, 0, 1);
        push_exp(K_COIN, 9, 1);
        buy(0);
        wait_idle("chg50");
        check_output("chg50_credit", 32'(o_credit), 0);

        // insufficient credit leaves credit untouched
        insert(8);
        buy(0);
        wait_idle("short");
        check_output("short_credit", 32'(o_credit), 100);

        // cancel beats simultaneous coin and buy
        push_exp(K_COIN, 8, 1);
        i_cancel = 1'b1;
        i_money = 4'd8;
        i_money_valid = 1'b1;
        i_buy = 1'b1;
        tick();
        i_cancel = 1'b0;
        i_money_valid = 1'b0;
        i_buy = 1'b0;
        wait_idle("prio");
        check_output("prio_credit", 32'(o_credit), 0);

        // cancel with zero credit and an out-of-range coin are both ignored
        cancel();
        check_output("cancel0_busy", 32'(o_busy), 0);
        insert(15);
        tick();
        check_output("badcoin_credit", 32'(o_credit), 0);

        // dispenser stalls while coins and buys are ignored
        insert(8);
        insert(9);
        i_product_ready = 1'b0;
        buy(0);
        tick();
        for (int i = 0; i < 5; i++) begin
            i_money = 4'd8;
            i_money_valid = (i % 2 == 0);
            i_buy = (i % 2 == 0);
            tick();
            check_output("stall_pvalid", 32'(o_product_valid), 1);
            check_output("stall_busy", 32'(o_busy), 1);
            check_output("stall_credit", 32'(o_credit), 0);
        end
        i_money_valid = 1'b0;
        i_buy = 1'b0;
        push_exp(K_VEND, 0, 1);
        i_product_ready = 1'b1;
        wait_idle("stall");
        check_output("stall_end_credit", 32'(o_credit), 0);

        // credit overflow: 20 x 50000 fits, the 21st coin is echoed back
        for (int i = 0; i < 20; i++) insert(0);
        check_output("big_credit", 32'(o_credit), 1000000);
        push_exp(K_COIN, 0, 1);
        insert(0);
        check_output("ovf_credit", 32'(o_credit), 1000000);

        // reset in the middle of returning the big credit
        cancel();
        push_exp(K_COIN, 0, 1);
        tick();
        check_output("midchg_busy", 32'(o_busy), 1);
        check_output("midchg_credit", 32'(o_credit), 950000);
        @(negedge i_clk);
        #1;
        do_reset("rst_midchg");
        check_output("rst_queue_empty", 32'(exp_q.size()), 0);

        // exhaust product 3 then hit sold-out; cancel returns the 500
        for (int i = 0; i < 10; i++) begin
            insert(8);
            insert(9);
            push_exp(K_VEND, 3, 1);
            buy(3);
            wait_idle("stock3");
        end
        insert(6);
        push_exp(K_SOLD, 0, 1);
        buy(3);
        wait_idle("sold");
        check_output("sold_credit", 32'(o_credit), 500);
        push_exp(K_COIN, 6, 1);
        cancel();
        wait_idle("sold_cancel");
        check_output("sold_cancel_credit", 32'(o_credit), 0);

        // drain every coin of 50 and below, then change cannot be made
        do_reset("rst_drain");
        for (int t = 0; t < 18; t++) begin
            int code;
            int n;
            if (t < 10) begin code = 9; n = 1; end
            else if (t < 15) begin code = 10; n = 2; end
            else if (t < 17) begin code = 11; n = 5; end
            else begin code = 12; n = 10; end
            insert(7);
            push_exp(K_VEND, (t < 10) ? 4 : 5, 1);
            push_exp(K_COIN, code, n);
            buy((t < 10) ? 4 : 5);
            wait_idle("drain");
            check_output("drain_credit", 32'(o_credit), 0);
        end
        insert(7);
        push_exp(K_VEND, 7, 1);
        push_exp(K_COIN, 13, 10);
        push_exp(K_COIN, 14, 10);
        buy(7);
        wait_idle("drain30");
        check_output("drain30_credit", 32'(o_credit), 0);
        insert(7);
        push_exp(K_VEND, 0, 1);
        push_exp(K_NOCHG, 0, 1);
        buy(0);
        wait_idle("nochg");
        check_output("nochg_credit", 32'(o_credit), 50);

        check_output("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
